// File: rtl/opamp_ctrl_pkg.sv
// Shared types and constants for the op-amp bring-up sequencer.
// State codes, register map, pad patterns and reset values.
package opamp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_BIAS = 3'd1,
    ST_CASC = 3'd2,
    ST_CONN = 3'd3,
    ST_ON   = 3'd4,
    ST_DISC = 3'd5
  } state_e;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_SETTLE = 4'h4;
  localparam logic [3:0] OFS_OEB    = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_SPARE_LSB  = 4;
  localparam int STAT_READY_BIT  = 3;
  localparam int STAT_PEND_BIT   = 4;

  localparam int PIN_BIAS   = 0;
  localparam int PIN_CASC   = 1;
  localparam int PIN_IN_SW  = 2;
  localparam int PIN_OUT_SW = 3;

  localparam logic [3:0] PADS_OFF  = 4'b0000;
  localparam logic [3:0] PADS_BIAS = 4'b0001 << PIN_BIAS;
  localparam logic [3:0] PADS_CASC = PADS_BIAS | (4'b0001 << PIN_CASC);
  localparam logic [3:0] PADS_CONN = PADS_CASC | (4'b0001 << PIN_IN_SW) | (4'b0001 << PIN_OUT_SW);
  localparam logic [3:0] PADS_ON   = PADS_CONN;
  localparam logic [3:0] PADS_DISC = PADS_CASC;

  localparam int SETTLE_RST = 100;

  function automatic logic [3:0] pads_for(input state_e s);
    case (s)
      ST_OFF:  pads_for = PADS_OFF;
      ST_BIAS: pads_for = PADS_BIAS;
      ST_CASC: pads_for = PADS_CASC;
      ST_CONN: pads_for = PADS_CONN;
      ST_ON:   pads_for = PADS_ON;
      ST_DISC: pads_for = PADS_DISC;
      default: pads_for = PADS_OFF;
    endcase
  endfunction

  function automatic logic is_busy(input state_e s);
    case (s)
      ST_BIAS, ST_CASC, ST_CONN, ST_DISC: is_busy = 1'b1;
      default:                            is_busy = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/opamp_ctrl_regs.sv
// Wishbone register block: decode, byte-lane writes, read mux and the
// sticky ON interrupt flag (hardware set beats a same-cycle W1C).
module opamp_ctrl_regs
  import opamp_ctrl_pkg::*;
#(
  parameter int          SETTLE_W  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic [31:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic                ack_o,
  output logic [31:0]         dat_o,
  input  state_e              state_i,
  input  logic                on_entry_i,
  output logic                en_o,
  output logic                irq_en_o,
  output logic [1:0]          spare_o,
  output logic [SETTLE_W-1:0] settle_o,
  output logic [5:0]          oeb_o,
  output logic                irq_pend_o
);

  logic                req_s, wr_s, wr_ctrl_s, wr_settle_s, wr_oeb_s, w1c_s;
  logic [31:0]         rdata_s, bmask_s;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                en_q, en_d, irq_en_q, irq_en_d, pend_q, pend_d;
  logic [1:0]          spare_q, spare_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [5:0]          oeb_q, oeb_d;

  assign req_s       = cyc_i & stb_i & ~ack_q & (adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_s        = req_s & we_i;
  assign wr_ctrl_s   = wr_s & (adr_i[3:0] == OFS_CTRL) & sel_i[0];
  assign wr_settle_s = wr_s & (adr_i[3:0] == OFS_SETTLE);
  assign wr_oeb_s    = wr_s & (adr_i[3:0] == OFS_OEB) & sel_i[0];
  assign w1c_s       = wr_s & (adr_i[3:0] == OFS_STATUS) & sel_i[0] & dat_i[STAT_PEND_BIT];
  assign bmask_s     = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rdata_s = 32'd0;
    case (adr_i[3:0])
      OFS_CTRL: begin
        rdata_s[CTRL_EN_BIT]                         = en_q;
        rdata_s[CTRL_IRQ_EN_BIT]                     = irq_en_q;
        rdata_s[CTRL_SPARE_LSB+1:CTRL_SPARE_LSB]     = spare_q;
      end
      OFS_SETTLE: rdata_s[SETTLE_W-1:0] = settle_q;
      OFS_OEB:    rdata_s[5:0]          = oeb_q;
      OFS_STATUS: begin
        rdata_s[2:0]            = state_i;
        rdata_s[STAT_READY_BIT] = (state_i == ST_ON);
        rdata_s[STAT_PEND_BIT]  = pend_q;
      end
      default: rdata_s = 32'd0;
    endcase
  end

  // Next values of the register file and bus response.
  always_comb begin
    ack_d    = req_s;
    dat_d    = (req_s & ~we_i) ? rdata_s : 32'd0;
    en_d     = wr_ctrl_s ? dat_i[CTRL_EN_BIT] : en_q;
    irq_en_d = wr_ctrl_s ? dat_i[CTRL_IRQ_EN_BIT] : irq_en_q;
    spare_d  = wr_ctrl_s ? dat_i[CTRL_SPARE_LSB+1:CTRL_SPARE_LSB] : spare_q;
    settle_d = wr_settle_s ? ((settle_q & ~bmask_s[SETTLE_W-1:0]) | (dat_i[SETTLE_W-1:0] & bmask_s[SETTLE_W-1:0]))
                           : settle_q;
    oeb_d    = wr_oeb_s ? dat_i[5:0] : oeb_q;
    pend_d   = on_entry_i ? 1'b1 : (w1c_s ? 1'b0 : pend_q);
  end

  // Register file and bus response flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      spare_q  <= 2'd0;
      settle_q <= SETTLE_W'(SETTLE_RST);
      oeb_q    <= 6'h3F;
      pend_q   <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      spare_q  <= spare_d;
      settle_q <= settle_d;
      oeb_q    <= oeb_d;
      pend_q   <= pend_d;
    end
  end

  assign ack_o      = ack_q;
  assign dat_o      = dat_q;
  assign en_o       = en_q;
  assign irq_en_o   = irq_en_q;
  assign spare_o    = spare_q;
  assign settle_o   = settle_q;
  assign oeb_o      = oeb_q;
  assign irq_pend_o = pend_q;

endmodule

// File: rtl/opamp_seq_ctrl.sv
// Op-amp power/bias sequencer top: bring-up/tear-down FSM, settle counter
// and registered pad drive, configured through opamp_ctrl_regs.
module opamp_seq_ctrl
  import opamp_ctrl_pkg::*;
#(
  parameter int          SETTLE_W  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [5:0]  ctrl_out,
  output logic [5:0]  ctrl_oeb,
  output logic        irq,
  output logic        busy
);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d, settle_s;
  logic [5:0]          ctrl_q, ctrl_d, oeb_s;
  logic                busy_q, busy_d;
  logic                en_s, irq_en_s, irq_pend_s, expired_s, load_s, on_entry_s;
  logic [1:0]          spare_s;

  opamp_ctrl_regs #(
    .SETTLE_W  (SETTLE_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .cyc_i      (wbs_cyc_i),
    .stb_i      (wbs_stb_i),
    .we_i       (wbs_we_i),
    .sel_i      (wbs_sel_i),
    .adr_i      (wbs_adr_i),
    .dat_i      (wbs_dat_i),
    .ack_o      (wbs_ack_o),
    .dat_o      (wbs_dat_o),
    .state_i    (state_q),
    .on_entry_i (on_entry_s),
    .en_o       (en_s),
    .irq_en_o   (irq_en_s),
    .spare_o    (spare_s),
    .settle_o   (settle_s),
    .oeb_o      (oeb_s),
    .irq_pend_o (irq_pend_s)
  );

  assign expired_s  = (cnt_q == '0);
  assign load_s     = (state_d != state_q) && (state_d != ST_OFF) && (state_d != ST_ON);
  assign on_entry_s = (state_d == ST_ON) && (state_q != ST_ON);
  assign cnt_d      = load_s ? settle_s : (expired_s ? cnt_q : cnt_q - SETTLE_W'(1));

  // State, counter and pad registers all update on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      ctrl_q  <= 6'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; DISC ignores EN so closed switches are always drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  state_d = en_s ? ST_BIAS : ST_OFF;
      ST_BIAS: state_d = !en_s ? ST_OFF  : (expired_s ? ST_CASC : ST_BIAS);
      ST_CASC: state_d = !en_s ? ST_OFF  : (expired_s ? ST_CONN : ST_CASC);
      ST_CONN: state_d = !en_s ? ST_DISC : (expired_s ? ST_ON   : ST_CONN);
      ST_ON:   state_d = !en_s ? ST_DISC : ST_ON;
      ST_DISC: state_d = expired_s ? ST_OFF : ST_DISC;
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    ctrl_d = {spare_s, pads_for(state_d)};
    busy_d = is_busy(state_d);
  end

  assign ctrl_out = ctrl_q;
  assign busy     = busy_q;
  assign ctrl_oeb = oeb_s;
  assign irq      = irq_pend_s & irq_en_s;

endmodule

// File: tb/tb_opamp_seq_ctrl.sv
// Directed bench for opamp_seq_ctrl: register-access vector table plus
// hand-timed sequences for bring-up, tear-down, abort and reset.
module tb_opamp_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack, irq, busy;
  logic [5:0]  ctrl_out, ctrl_oeb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  opamp_seq_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .ctrl_out  (ctrl_out),
    .ctrl_oeb  (ctrl_oeb),
    .irq       (irq),
    .busy      (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus request; returns ack and data sampled just after the ack edge.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic got_ack, output logic [31:0] got_dat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    got_ack = ack;
    got_dat = rdat;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic        a;
    logic [31:0] r;
    wb_access(1'b1, BASE + off, d, s, a, r);
    check($sformatf("wr_ack_%h", off), {31'd0, a}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
    logic        a;
    logic [31:0] r;
    wb_access(1'b0, BASE + off, 32'd0, 4'hF, a, r);
    check({name, "_ack"}, {31'd0, a}, 32'd1);
    check(name, r, exp);
  endtask

  initial begin
    logic        a;
    logic [31:0] r;
    logic [3:0]  exp_p;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl_out", {26'd0, ctrl_out}, 32'h00);
    check("rst_oeb", {26'd0, ctrl_oeb}, 32'h3F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 32'h000, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h004, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0064};
    vecs[2]  = '{1'b0, 32'h008, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_003F};
    vecs[3]  = '{1'b0, 32'h00C, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 32'h004, 32'h0000_1234, 4'hF, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h004, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_1234};
    vecs[6]  = '{1'b1, 32'h004, 32'h0000_ABCD, 4'h1, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b0, 32'h004, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_12CD};
    vecs[8]  = '{1'b1, 32'h008, 32'hFFFF_FF15, 4'hF, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h008, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0015};
    vecs[10] = '{1'b1, 32'h000, 32'h0000_00F0, 4'hF, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h000, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0030};
    vecs[12] = '{1'b1, 32'h00C, 32'h0000_00FF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b0, 32'h00C, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[14] = '{1'b0, 32'h002, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[15] = '{1'b1, 32'h006, 32'h0000_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[16] = '{1'b0, 32'h004, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_12CD};
    vecs[17] = '{1'b0, 32'h100, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[18] = '{1'b1, 32'h104, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[19] = '{1'b1, 32'h004, 32'h0000_0002, 4'hF, 1'b1, 32'h0000_0000};
    vecs[20] = '{1'b0, 32'h004, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0002};

    for (int i = 0; i < 21; i++) begin
      wb_access(vecs[i].we, BASE + vecs[i].off, vecs[i].dat, vecs[i].sel, a, r);
      check($sformatf("vec%0d_ack", i), {31'd0, a}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d_dat", i), r, vecs[i].exp_rd);
    end
    check("spare_pads", {26'd0, ctrl_out}, 32'h30);
    check("oeb_pads", {26'd0, ctrl_oeb}, 32'h15);

    // Bring-up with SETTLE=2: BIAS E+1, CASC E+4, CONN E+7, ON E+10.
    wr(32'h0, 32'h3, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_p = (k <= 3) ? 4'h1 : ((k <= 6) ? 4'h3 : 4'hF);
      check($sformatf("ramp_pads_k%0d", k), {28'd0, ctrl_out[3:0]}, {28'd0, exp_p});
      check($sformatf("ramp_busy_k%0d", k), {31'd0, busy}, (k <= 9) ? 32'd1 : 32'd0);
      check($sformatf("ramp_irq_k%0d", k), {31'd0, irq}, (k >= 10) ? 32'd1 : 32'd0);
    end
    rd(32'hC, 32'h1C, "status_on");

    // Tear-down; re-enabling during DISC does not shorten it.
    wr(32'h0, 32'h2, 4'hF);
    @(posedge clk); #1;
    check("disc_k1_pads", {26'd0, ctrl_out}, 32'h03);
    check("disc_k1_busy", {31'd0, busy}, 32'd1);
    wr(32'h0, 32'h3, 4'hF);
    @(posedge clk); #1;
    check("disc_k3_pads", {26'd0, ctrl_out}, 32'h03);
    @(posedge clk); #1;
    check("off_k4_pads", {26'd0, ctrl_out}, 32'h00);
    check("off_k4_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("bias_k5_pads", {26'd0, ctrl_out}, 32'h01);
    repeat (12) @(posedge clk);
    #1;
    check("reon_pads", {26'd0, ctrl_out}, 32'h0F);
    check("reon_busy", {31'd0, busy}, 32'd0);
    check("reon_irq", {31'd0, irq}, 32'd1);
    wr(32'hC, 32'h10, 4'h1);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    rd(32'hC, 32'h0C, "status_w1c");

    // Long tear-down with SETTLE=50, then abort during BIAS.
    wr(32'h4, 32'd50, 4'hF);
    wr(32'h0, 32'h2, 4'hF);
    @(posedge clk); #1;
    check("disc50_pads", {26'd0, ctrl_out}, 32'h03);
    repeat (60) @(posedge clk);
    #1;
    check("disc50_done_pads", {26'd0, ctrl_out}, 32'h00);
    check("disc50_done_busy", {31'd0, busy}, 32'd0);
    rd(32'hC, 32'h00, "status_off");
    wr(32'h0, 32'h3, 4'hF);
    @(posedge clk); #1;
    check("abort_bias_pads", {26'd0, ctrl_out}, 32'h01);
    check("abort_bias_busy", {31'd0, busy}, 32'd1);
    wr(32'h0, 32'h2, 4'hF);
    @(posedge clk); #1;
    check("abort_off_pads", {26'd0, ctrl_out}, 32'h00);
    check("abort_off_busy", {31'd0, busy}, 32'd0);

    // Reset asserted while in CONN.
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h0, 32'h3, 4'hF);
    repeat (7) @(posedge clk);
    #1;
    check("conn_pads", {26'd0, ctrl_out}, 32'h0F);
    check("conn_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pads", {26'd0, ctrl_out}, 32'h00);
    check("mid_rst_oeb", {26'd0, ctrl_oeb}, 32'h3F);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_dat", rdat, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h0, 32'h00, "post_rst_ctrl");
    rd(32'h4, 32'h64, "post_rst_settle");
    rd(32'h8, 32'h3F, "post_rst_oeb");
    rd(32'hC, 32'h00, "post_rst_status");
    @(posedge clk); #1;
    check("post_rst_pads", {26'd0, ctrl_out}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opamp_seq_ctrl.md
# opamp_seq_ctrl

Wishbone-configured power/bias sequencer for the cascode op-amp macro in the user project area. It owns the six analog-control GPIO pads and drives them through a fixed, timed bring-up order: bias, cascode bias, then input/output switches. Tear-down runs in reverse. It raises an interrupt when the amplifier is fully on. It sits beside the op-amp in the wrapper, on the Caravel Wishbone bus, in the `vccd1`/`vssd1` domain.

## Interface
- `SETTLE_W`, 16: width of the per-step settle counter.
- `BASE_ADDR`, 32'h3000_0100: register block base; decode compares `wbs_adr_i[31:4]` only.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe, write enable.
- `wbs_sel_i`  in  4  byte selects, honoured on writes.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid with ack, 0 otherwise.
- `ctrl_out`  out  6  pad drive:
  - [0] bias_en
  - [1] casc_en
  - [2] in_sw
  - [3] out_sw
  - [5:4] spare, from CTRL.
- `ctrl_oeb`  out  6  pad output-enable-bar, from the OEB register.
- `irq`  out  1  level interrupt, equal to `irq_pend & IRQ_EN`.
- `busy`  out  1  high in the BIAS, CASC, CONN and DISC states.

## Operation
- Registers (byte offsets):
  - 0x0 CTRL, RW: [0] EN, [1] IRQ_EN, [5:4] SPARE. Reset 0.
  - 0x4 SETTLE, RW: [SETTLE_W-1:0]. Reset 100.
  - 0x8 OEB, RW: [5:0]. Reset 6'h3F, so all pads are hi-Z.
  - 0xC STATUS: [2:0] state code, [3] ready (state==ON), [4] irq_pend. Writing 1 to bit 4 clears irq_pend; other STATUS bits ignore writes.
- Unmapped offsets inside the block read 0 and ignore writes, but are still acked. Addresses outside the block get no ack.
- FSM states and codes: OFF=0, BIAS=1, CASC=2, CONN=3, ON=4, DISC=5.
- Pad outputs ctrl_out[3:0] per state:
  - OFF 0000
  - BIAS 0001
  - CASC 0011
  - CONN 1111
  - ON 1111
  - DISC 0011
- Settle counter: loaded with SETTLE on entry to BIAS, CASC, CONN and DISC. It decrements every cycle; the step advances on the edge where the counter is 0. Every timed step therefore dwells SETTLE+1 cycles (SETTLE=0 gives 1 cycle).
- Transitions:
  - OFF→BIAS when EN=1.
  - BIAS→CASC, CASC→CONN, CONN→ON on counter expiry, while EN=1.
  - EN=0 in BIAS or CASC → OFF on the next edge; no switches are closed yet, so no drain step.
  - EN=0 in CONN or ON → DISC.
  - DISC always runs to expiry, then → OFF, regardless of EN.
  - OFF with EN=1 restarts the sequence.
- irq_pend is set on the edge that enters ON. Simultaneous entry to ON and a W1C write: the set wins.
- A SETTLE write takes effect at the next counter load; the running count is unaffected.

## Timing
- Wishbone:
  - A request is `cyc & stb & !ack`. Ack rises the following cycle for exactly one cycle.
  - Write data commits on the edge that raises ack.
  - Back-to-back requests are acked every other cycle.
- ctrl_out and busy are registered and change on the same edge as the state register. No combinational path from the bus to the pads.
- Latency from EN=1 commit at edge E:
  - BIAS entered at E+1.
  - ON entered at E+1+3·(SETTLE+1).
  - irq visible in the same cycle as ON, if IRQ_EN=1.
- Reset (`wb_rst_i` sampled high at any edge, including mid-sequence):
  - state OFF, ctrl_out 0, ctrl_oeb 6'h3F
  - ack 0, dat_o 0, irq 0, busy 0
  - registers return to reset values, counter 0.

## Structure
- Package `opamp_ctrl_pkg` holds:
  - state enum and codes
  - register offsets and CTRL/STATUS bit positions
  - ctrl_out pin indices and per-state pad pattern constants
  - SETTLE reset value.
- One sub-module, `opamp_ctrl_regs`: Wishbone decode, byte-lane writes, register file, read mux, W1C handling. It exports EN, IRQ_EN, SPARE, SETTLE and OEB, and takes in state and the ON-entry pulse.
- The top level holds the FSM, the settle counter and the output registers.

## Test plan
- Reset → ctrl_out=0, ctrl_oeb=3F. Reads: CTRL=0, SETTLE=100, OEB=3F, STATUS=0.
- SETTLE=2, then CTRL=0x3:
  - BIAS at E+1, CASC at E+4, CONN at E+7, ON at E+10.
  - ctrl_out[3:0] follows 1→3→F; irq=1 at E+10.
- From ON, write CTRL=0 → DISC (pads 0011) for 3 cycles → OFF (0000). Re-writing EN=1 during DISC does not shorten it; BIAS follows OFF by 1 cycle.
- EN cleared during BIAS (SETTLE=50) → OFF next edge, pads 0, busy 0.
- Write 0x10 to STATUS → irq_pend and irq clear. A write with sel=4'b0001 to SETTLE=0xABCD changes only the low byte.
- Access at BASE_ADDR+0x100 → no ack. `wb_rst_i` asserted in CONN → all outputs reach reset values at that edge.
